// File: rtl/rom_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rom_arbiter_pkg
// Description : Shared constants for the instruction-ROM arbiter: bus widths,
//               chip-enable levels and FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package rom_arbiter_pkg;

    localparam int unsigned C_INST_ADDR_BUS_W = 32;
    localparam int unsigned C_INST_BUS_W      = 32;
    localparam int unsigned C_DBG_LEN_BUS_W   = 3;

    localparam logic C_CHIP_ENABLE  = 1'b1;
    localparam logic C_CHIP_DISABLE = 1'b0;

    localparam logic [0:0] C_ROM_ARB_IDLE  = 1'b0;
    localparam logic [0:0] C_ROM_ARB_BURST = 1'b1;

endpackage : rom_arbiter_pkg
`default_nettype wire

// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rom_arbiter
// Description : Shares one combinational ROM read port between instruction
//               fetch and a debug burst port, round-robin, 1-cycle data latency.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = C_INST_ADDR_BUS_W,
    parameter int unsigned DATA_W = C_INST_BUS_W,
    parameter int unsigned LEN_W  = C_DBG_LEN_BUS_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [LEN_W-1:0]  dbg_len,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_done,

    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst,

    output logic              busy
);

    logic [0:0]        state_q,      state_d;
    logic              rr_dbg_q,     rr_dbg_d;
    logic [ADDR_W-1:0] nxt_addr_q,   nxt_addr_d;
    logic [LEN_W-1:0]  beats_left_q, beats_left_d;
    logic              if_rvalid_q,  if_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q,   if_rdata_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;
    logic [DATA_W-1:0] dbg_rdata_q,  dbg_rdata_d;
    logic              dbg_done_q,   dbg_done_d;

    logic              w_in_burst;
    logic              w_fetch_win;
    logic              w_dbg_win;

    assign w_in_burst = (state_q == C_ROM_ARB_BURST);

    // Grants are gated by rst_n so they drop the instant reset is asserted.
    always_comb begin
        w_fetch_win = 1'b0;
        w_dbg_win   = 1'b0;
        if (rst_n && !w_in_burst) begin
            if (if_req && (!dbg_req || !rr_dbg_q)) begin
                w_fetch_win = 1'b1;
            end else if (dbg_req) begin
                w_dbg_win = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_dbg_d     = rr_dbg_q;
        nxt_addr_d   = nxt_addr_q;
        beats_left_d = beats_left_q;
        if_rvalid_d  = 1'b0;
        if_rdata_d   = if_rdata_q;
        dbg_rvalid_d = 1'b0;
        dbg_rdata_d  = dbg_rdata_q;
        dbg_done_d   = 1'b0;
        rom_ce       = C_CHIP_DISABLE;
        rom_addr     = '0;

        if (w_fetch_win) begin
            rom_ce      = C_CHIP_ENABLE;
            rom_addr    = if_addr;
            if_rvalid_d = 1'b1;
            if_rdata_d  = rom_inst;
            rr_dbg_d    = 1'b1;
        end else if (w_dbg_win) begin
            rom_ce       = C_CHIP_ENABLE;
            rom_addr     = dbg_addr;
            dbg_rvalid_d = 1'b1;
            dbg_rdata_d  = rom_inst;
            dbg_done_d   = (dbg_len == '0);
            nxt_addr_d   = dbg_addr + ADDR_W'(4);
            beats_left_d = dbg_len;
            rr_dbg_d     = 1'b0;
            if (dbg_len != '0) begin
                state_d = C_ROM_ARB_BURST;
            end
        end else if (w_in_burst) begin
            // beats_left_q counts the beats still to issue, including this one.
            rom_ce       = C_CHIP_ENABLE;
            rom_addr     = nxt_addr_q;
            dbg_rvalid_d = 1'b1;
            dbg_rdata_d  = rom_inst;
            dbg_done_d   = (beats_left_q == LEN_W'(1));
            nxt_addr_d   = nxt_addr_q + ADDR_W'(4);
            beats_left_d = beats_left_q - LEN_W'(1);
            if (beats_left_q == LEN_W'(1)) begin
                state_d = C_ROM_ARB_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= C_ROM_ARB_IDLE;
            rr_dbg_q     <= 1'b0;
            nxt_addr_q   <= '0;
            beats_left_q <= '0;
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
            dbg_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_dbg_q     <= rr_dbg_d;
            nxt_addr_q   <= nxt_addr_d;
            beats_left_q <= beats_left_d;
            if_rvalid_q  <= if_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_rdata_q  <= dbg_rdata_d;
            dbg_done_q   <= dbg_done_d;
        end
    end

    assign if_gnt     = w_fetch_win;
    assign dbg_gnt    = w_dbg_win;
    assign busy       = w_in_burst;
    assign if_rvalid  = if_rvalid_q;
    assign if_rdata   = if_rdata_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign dbg_done   = dbg_done_q;

endmodule : rom_arbiter
`default_nettype wire

// File: tb/tb_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_arbiter
// Description : Directed and randomized self-checking bench for rom_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              dbg_req;
    logic [31:0]       dbg_addr;
    logic [2:0]        dbg_len;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [31:0]       dbg_rdata;
    logic              dbg_done;
    logic              rom_ce;
    logic [31:0]       rom_addr;
    logic [31:0]       rom_inst;
    logic              busy;

    logic [31:0] mem [64];

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: pending burst addresses plus the data expected next cycle.
    logic        m_rr;
    logic [31:0] m_burst [$];
    logic        m_if_v, m_dbg_v, m_dbg_done;
    logic [31:0] m_if_d, m_dbg_d;

    always #5 clk = ~clk;

    assign rom_inst = mem[rom_addr[7:2]];

    rom_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .dbg_req    (dbg_req),
        .dbg_addr   (dbg_addr),
        .dbg_len    (dbg_len),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .dbg_done   (dbg_done),
        .rom_ce     (rom_ce),
        .rom_addr   (rom_addr),
        .rom_inst   (rom_inst),
        .busy       (busy)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return mem[a[7:2]];
    endfunction

    task automatic drive(input logic ir, input logic [31:0] ia,
                         input logic dr, input logic [31:0] da, input logic [2:0] dl);
        if_req   = ir;
        if_addr  = ia;
        dbg_req  = dr;
        dbg_addr = da;
        dbg_len  = dl;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b1, 32'h4, 1'b1, 32'h0, 3'd7);
        #1;
        total_cnt++; if (if_gnt !== 1'b0) $display("FAIL rst_if_gnt: got %b want 0", if_gnt); else pass_cnt++;
        total_cnt++; if (dbg_gnt !== 1'b0) $display("FAIL rst_dbg_gnt: got %b want 0", dbg_gnt); else pass_cnt++;
        total_cnt++; if (rom_ce !== 1'b0) $display("FAIL rst_rom_ce: got %b want 0", rom_ce); else pass_cnt++;
        total_cnt++; if (rom_addr !== 32'h0) $display("FAIL rst_rom_addr: got %h want 0", rom_addr); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if ({if_rvalid, dbg_rvalid, dbg_done} !== 3'b000)
            $display("FAIL rst_valids: got %b want 000", {if_rvalid, dbg_rvalid, dbg_done}); else pass_cnt++;
        total_cnt++; if ({if_rdata, dbg_rdata} !== 64'h0)
            $display("FAIL rst_rdata: got %h want 0", {if_rdata, dbg_rdata}); else pass_cnt++;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        drive(1'b1, 32'h4, 1'b0, 32'h0, 3'd0);
        #1;
        total_cnt++; if (if_gnt !== 1'b1) $display("FAIL fetch_gnt: got %b want 1", if_gnt); else pass_cnt++;
        total_cnt++; if (rom_ce !== 1'b1 || rom_addr !== 32'h4)
            $display("FAIL fetch_issue: got ce=%b addr=%h want ce=1 addr=4", rom_ce, rom_addr); else pass_cnt++;
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
        #1;
        total_cnt++; if (if_rvalid !== 1'b1) $display("FAIL fetch_rvalid: got %b want 1", if_rvalid); else pass_cnt++;
        total_cnt++; if (if_rdata !== 32'h00102023) $display("FAIL fetch_rdata: got %h want 00102023", if_rdata); else pass_cnt++;
        total_cnt++; if (rom_ce !== 1'b0) $display("FAIL fetch_idle_ce: got %b want 0", rom_ce); else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h00102023)
            $display("FAIL fetch_hold: got v=%b d=%h want v=0 d=00102023", if_rvalid, if_rdata); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_dbg_burst();
        drive(1'b0, 32'h0, 1'b1, 32'h0, 3'd1);
        #1;
        total_cnt++; if (dbg_gnt !== 1'b1 || rom_addr !== 32'h0)
            $display("FAIL dbg_grant: got gnt=%b addr=%h want gnt=1 addr=0", dbg_gnt, rom_addr); else pass_cnt++;
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
        #1;
        total_cnt++; if (busy !== 1'b1 || dbg_gnt !== 1'b0 || rom_addr !== 32'h4)
            $display("FAIL dbg_beat1_issue: got busy=%b gnt=%b addr=%h want 1 0 4", busy, dbg_gnt, rom_addr); else pass_cnt++;
        total_cnt++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hFFF00093 || dbg_done !== 1'b0)
            $display("FAIL dbg_beat0_data: got v=%b d=%h done=%b want 1 fff00093 0", dbg_rvalid, dbg_rdata, dbg_done); else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h00102023 || dbg_done !== 1'b1)
            $display("FAIL dbg_beat1_data: got v=%b d=%h done=%b want 1 00102023 1", dbg_rvalid, dbg_rdata, dbg_done); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL dbg_end_busy: got %b want 0", busy); else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++; if (dbg_rvalid !== 1'b0 || dbg_done !== 1'b0)
            $display("FAIL dbg_after: got v=%b done=%b want 0 0", dbg_rvalid, dbg_done); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [31:0] a;
        a = 32'hFFFF_FFF8;
        drive(1'b0, 32'h0, 1'b1, a, 3'd3);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) drive(1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
            #1;
            total_cnt++; if (rom_ce !== 1'b1 || rom_addr !== a)
                $display("FAIL wrap_addr%0d: got ce=%b addr=%h want ce=1 addr=%h", k, rom_ce, rom_addr, a); else pass_cnt++;
            a = a + 32'd4;
            @(negedge clk);
        end
        #1;
        total_cnt++; if (dbg_done !== 1'b1 || dbg_rdata !== rom_word(32'h4))
            $display("FAIL wrap_last: got done=%b d=%h want done=1 d=%h", dbg_done, dbg_rdata, rom_word(32'h4)); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_rr_burst();
        apply_reset();
        drive(1'b1, 32'h8, 1'b1, 32'h20, 3'd7);
        #1;
        total_cnt++; if (if_gnt !== 1'b1 || dbg_gnt !== 1'b0)
            $display("FAIL rr_first: got if=%b dbg=%b want 1 0", if_gnt, dbg_gnt); else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++; if (dbg_gnt !== 1'b1 || if_gnt !== 1'b0 || rom_addr !== 32'h20)
            $display("FAIL rr_second: got dbg=%b if=%b addr=%h want 1 0 20", dbg_gnt, if_gnt, rom_addr); else pass_cnt++;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            #1;
            total_cnt++; if (if_gnt !== 1'b0 || dbg_gnt !== 1'b0 || busy !== 1'b1)
                $display("FAIL rr_burst_gnt%0d: got if=%b dbg=%b busy=%b want 0 0 1", k, if_gnt, dbg_gnt, busy); else pass_cnt++;
            total_cnt++; if (rom_addr !== 32'h20 + 32'(4 * k))
                $display("FAIL rr_burst_addr%0d: got %h want %h", k, rom_addr, 32'h20 + 32'(4 * k)); else pass_cnt++;
            total_cnt++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== rom_word(32'h20 + 32'(4 * (k - 1))))
                $display("FAIL rr_burst_data%0d: got v=%b d=%h want 1 %h", k, dbg_rvalid, dbg_rdata,
                         rom_word(32'h20 + 32'(4 * (k - 1)))); else pass_cnt++;
        end
        @(negedge clk);
        #1;
        total_cnt++; if (if_gnt !== 1'b1 || dbg_done !== 1'b1 || dbg_rdata !== rom_word(32'h3C))
            $display("FAIL rr_return: got if=%b done=%b d=%h want 1 1 %h", if_gnt, dbg_done, dbg_rdata, rom_word(32'h3C)); else pass_cnt++;
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        drive(1'b0, 32'h0, 1'b1, 32'h40, 3'd7);
        #1;
        total_cnt++; if (dbg_gnt !== 1'b1) $display("FAIL mid_grant: got %b want 1", dbg_gnt); else pass_cnt++;
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
        repeat (2) @(negedge clk);
        #1;
        total_cnt++; if (busy !== 1'b1 || dbg_rvalid !== 1'b1 || rom_addr !== 32'h4C)
            $display("FAIL mid_beat3: got busy=%b v=%b addr=%h want 1 1 4c", busy, dbg_rvalid, rom_addr); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++; if ({busy, rom_ce, dbg_rvalid, dbg_done, if_rvalid, if_gnt, dbg_gnt} !== 7'b0)
            $display("FAIL mid_rst_ctrl: got %b want 0000000",
                     {busy, rom_ce, dbg_rvalid, dbg_done, if_rvalid, if_gnt, dbg_gnt}); else pass_cnt++;
        total_cnt++; if ({rom_addr, dbg_rdata, if_rdata} !== 96'h0)
            $display("FAIL mid_rst_data: got %h want 0", {rom_addr, dbg_rdata, if_rdata}); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'h8, 1'b0, 32'h0, 3'd0);
        #1;
        total_cnt++; if (busy !== 1'b0 || if_gnt !== 1'b1 || rom_addr !== 32'h8)
            $display("FAIL mid_refetch: got busy=%b gnt=%b addr=%h want 0 1 8", busy, if_gnt, rom_addr); else pass_cnt++;
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
        #1;
        total_cnt++; if (if_rvalid !== 1'b1 || if_rdata !== mem[2] || dbg_rvalid !== 1'b0)
            $display("FAIL mid_refetch_data: got v=%b d=%h dv=%b want 1 %h 0", if_rvalid, if_rdata, dbg_rvalid, mem[2]); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_alternation();
        apply_reset();
        drive(1'b1, 32'hC, 1'b0, 32'h0, 3'd0);
        #1;
        total_cnt++; if (if_gnt !== 1'b1 || dbg_gnt !== 1'b0)
            $display("FAIL alt_c0: got if=%b dbg=%b want 1 0", if_gnt, dbg_gnt); else pass_cnt++;
        @(negedge clk);
        drive(1'b1, 32'hC, 1'b1, 32'h10, 3'd0);
        #1;
        total_cnt++; if (if_gnt !== 1'b0 || dbg_gnt !== 1'b1)
            $display("FAIL alt_c1: got if=%b dbg=%b want 0 1", if_gnt, dbg_gnt); else pass_cnt++;
        @(negedge clk);
        drive(1'b1, 32'hC, 1'b0, 32'h0, 3'd0);
        #1;
        total_cnt++; if (if_gnt !== 1'b1 || dbg_gnt !== 1'b0)
            $display("FAIL alt_c2: got if=%b dbg=%b want 1 0", if_gnt, dbg_gnt); else pass_cnt++;
        total_cnt++; if (dbg_rvalid !== 1'b1 || dbg_done !== 1'b1 || dbg_rdata !== mem[4])
            $display("FAIL alt_single: got v=%b done=%b d=%h want 1 1 %h", dbg_rvalid, dbg_done, dbg_rdata, mem[4]); else pass_cnt++;
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
        @(negedge clk);
    endtask

    task automatic test_random();
        logic        ir, dr, e_fg, e_dg, e_ce, e_busy, e_issue, e_last;
        logic [31:0] ia, da, e_addr;
        logic [2:0]  dl;
        apply_reset();
        m_rr = 1'b0; m_burst.delete();
        m_if_v = 1'b0; m_if_d = '0; m_dbg_v = 1'b0; m_dbg_d = '0; m_dbg_done = 1'b0;
        ir = 1'b0; dr = 1'b0; ia = '0; da = '0; dl = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (ir) begin
                if ($urandom_range(7) == 0) ir = 1'b0;
            end else if ($urandom_range(1) == 0) begin
                ir = 1'b1; ia = $urandom;
            end
            if (dr) begin
                if ($urandom_range(7) == 0) dr = 1'b0;
            end else if ($urandom_range(3) == 0) begin
                dr = 1'b1; da = $urandom; dl = 3'($urandom_range(7));
            end
            drive(ir, ia, dr, da, dl);
            #1;
            e_busy = (m_burst.size() != 0);
            e_fg = 1'b0; e_dg = 1'b0; e_ce = 1'b0; e_addr = '0; e_issue = 1'b0; e_last = 1'b0;
            if (e_busy) begin
                e_ce = 1'b1; e_addr = m_burst.pop_front(); e_issue = 1'b1;
                e_last = (m_burst.size() == 0);
            end else if (ir && (!dr || !m_rr)) begin
                e_fg = 1'b1; e_ce = 1'b1; e_addr = ia;
            end else if (dr) begin
                e_dg = 1'b1; e_ce = 1'b1; e_addr = da; e_issue = 1'b1; e_last = (dl == 3'd0);
                for (int k = 1; k <= int'(dl); k++) m_burst.push_back(da + 32'(4 * k));
            end
            total_cnt++; if (if_gnt !== e_fg) $display("FAIL rnd_if_gnt c%0d: got %b want %b", cyc, if_gnt, e_fg); else pass_cnt++;
            total_cnt++; if (dbg_gnt !== e_dg) $display("FAIL rnd_dbg_gnt c%0d: got %b want %b", cyc, dbg_gnt, e_dg); else pass_cnt++;
            total_cnt++; if (rom_ce !== e_ce) $display("FAIL rnd_rom_ce c%0d: got %b want %b", cyc, rom_ce, e_ce); else pass_cnt++;
            total_cnt++; if (rom_addr !== e_addr) $display("FAIL rnd_rom_addr c%0d: got %h want %h", cyc, rom_addr, e_addr); else pass_cnt++;
            total_cnt++; if (busy !== e_busy) $display("FAIL rnd_busy c%0d: got %b want %b", cyc, busy, e_busy); else pass_cnt++;
            total_cnt++; if (if_rvalid !== m_if_v) $display("FAIL rnd_if_rvalid c%0d: got %b want %b", cyc, if_rvalid, m_if_v); else pass_cnt++;
            total_cnt++; if (if_rdata !== m_if_d) $display("FAIL rnd_if_rdata c%0d: got %h want %h", cyc, if_rdata, m_if_d); else pass_cnt++;
            total_cnt++; if (dbg_rvalid !== m_dbg_v) $display("FAIL rnd_dbg_rvalid c%0d: got %b want %b", cyc, dbg_rvalid, m_dbg_v); else pass_cnt++;
            total_cnt++; if (dbg_rdata !== m_dbg_d) $display("FAIL rnd_dbg_rdata c%0d: got %h want %h", cyc, dbg_rdata, m_dbg_d); else pass_cnt++;
            total_cnt++; if (dbg_done !== m_dbg_done) $display("FAIL rnd_dbg_done c%0d: got %b want %b", cyc, dbg_done, m_dbg_done); else pass_cnt++;
            m_if_v = e_fg;
            if (e_fg) m_if_d = rom_word(e_addr);
            m_dbg_v = e_issue;
            if (e_issue) m_dbg_d = rom_word(e_addr);
            m_dbg_done = e_last;
            if (e_fg) begin m_rr = 1'b1; ir = 1'b0; end
            if (e_dg) begin m_rr = 1'b0; dr = 1'b0; end
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'hFFF00093;
        mem[1] = 32'h00102023;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
        repeat (2) @(negedge clk);
        test_reset();
        test_fetch();
        test_dbg_burst();
        test_wrap();
        test_rr_burst();
        test_reset_mid_burst();
        test_alternation();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_rom_arbiter
`default_nettype wire
